// File: rtl/fwd_data_pipe.sv
// fwd_data_pipe: in-flight result store for operand forwarding and register-file writeback.
// Six slots track each result from EX2 through one cycle past WB:
// S1=EX2, S2=MEM1, S3=MEM2, S4=MEM3, S5=WB, S6=WRITTEN.
// Load data is merged into S4.
// S5 drives the register-file write port.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   EX_VALID/RD/TYPE    result entering EX2 (type 1 = alu, 2 = load, 0/3 = idle)
//   EX_RESULT           ALU result
//   LOAD_DATA(_VALID)   data-cache read data for the load sitting in S4
//   DATA_CACHE_READY,
//   INS_CACHE_READY     both high lets the pipe advance
//   STALL_ENABLE_FB     high lets the pipe advance past EX2
//   FLUSH               branch flush; kills the entries in S1 and S2
//   MUX1/2_SELECT       operand source: 0/7 register file, 1..6 slot S1..S6
//   RS1/2_REGFILE       register-file read data
//   RS1/2_DATA(_OK)     forwarded operand and its usability
//   WB_EN/RD/DATA       register-file write port
module fwd_data_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EX_VALID,
  input  logic [REG_ADDR_W-1:0] EX_RD,
  input  logic [1:0]            EX_TYPE,
  input  logic [DATA_WIDTH-1:0] EX_RESULT,
  input  logic [DATA_WIDTH-1:0] LOAD_DATA,
  input  logic                  LOAD_DATA_VALID,
  input  logic                  DATA_CACHE_READY,
  input  logic                  INS_CACHE_READY,
  input  logic                  STALL_ENABLE_FB,
  input  logic                  FLUSH,
  input  logic [2:0]            MUX1_SELECT,
  input  logic [2:0]            MUX2_SELECT,
  input  logic [DATA_WIDTH-1:0] RS1_REGFILE,
  input  logic [DATA_WIDTH-1:0] RS2_REGFILE,
  output logic [DATA_WIDTH-1:0] RS1_DATA,
  output logic [DATA_WIDTH-1:0] RS2_DATA,
  output logic                  RS1_DATA_OK,
  output logic                  RS2_DATA_OK,
  output logic                  WB_EN,
  output logic [REG_ADDR_W-1:0] WB_RD,
  output logic [DATA_WIDTH-1:0] WB_DATA
);

  // Slot fields, indexed 1..6 to match the select codes.
  logic [6:1]                 v_q, v_d;
  logic [6:1]                 ld_q, ld_d;
  logic [6:1]                 dv_q, dv_d;
  logic [6:1][REG_ADDR_W-1:0] rd_q, rd_d;
  logic [6:1][DATA_WIDTH-1:0] data_q, data_d;
  // Sticky: a load reached WB without its data.
  logic                       err_ld, err_ld_d;

  logic                  adv, adv_ex;
  logic                  v1_live, v2_live;
  logic                  ex_take, ex_alu;
  logic                  merge;
  logic                  dv4_m;
  logic [DATA_WIDTH-1:0] data4_m;

  assign adv    = DATA_CACHE_READY & INS_CACHE_READY;
  assign adv_ex = adv & STALL_ENABLE_FB;

  // A flush kills S1/S2 wherever they would go: held in place or shifted onward.
  assign v1_live = v_q[1] & ~FLUSH;
  assign v2_live = v_q[2] & ~FLUSH;

  assign ex_take = EX_VALID & ((EX_TYPE == 2'd1) | (EX_TYPE == 2'd2)) & ~FLUSH;
  assign ex_alu  = ex_take & (EX_TYPE == 2'd1);

  // Load merge view of S4; used both when S4 holds and when it shifts into S5.
  assign merge   = v_q[4] & ld_q[4] & ~dv_q[4] & LOAD_DATA_VALID;
  assign dv4_m   = dv_q[4] | merge;
  assign data4_m = merge ? LOAD_DATA : data_q[4];

  always_comb begin
    v_d      = v_q;
    ld_d     = ld_q;
    dv_d     = dv_q;
    rd_d     = rd_q;
    data_d   = data_q;
    err_ld_d = err_ld | (v_q[5] & ld_q[5] & ~dv_q[5]);

    v_d[1] = v1_live;
    v_d[2] = v2_live;

    if (adv_ex) begin
      v_d[1]    = ex_take;
      ld_d[1]   = ex_take & ~ex_alu;
      dv_d[1]   = ex_alu;
      rd_d[1]   = ex_take ? EX_RD : '0;
      data_d[1] = ex_alu ? EX_RESULT : '0;
    end

    if (adv) begin
      if (adv_ex) begin
        v_d[2]    = v1_live;
        ld_d[2]   = ld_q[1];
        dv_d[2]   = dv_q[1];
        rd_d[2]   = rd_q[1];
        data_d[2] = data_q[1];
      end else begin
        // S1 is held, so a bubble enters S2.
        v_d[2]    = 1'b0;
        ld_d[2]   = 1'b0;
        dv_d[2]   = 1'b0;
        rd_d[2]   = '0;
        data_d[2] = '0;
      end
      v_d[3]    = v2_live;
      ld_d[3]   = ld_q[2];
      dv_d[3]   = dv_q[2];
      rd_d[3]   = rd_q[2];
      data_d[3] = data_q[2];

      v_d[4]    = v_q[3];
      ld_d[4]   = ld_q[3];
      dv_d[4]   = dv_q[3];
      rd_d[4]   = rd_q[3];
      data_d[4] = data_q[3];

      v_d[5]    = v_q[4];
      ld_d[5]   = ld_q[4];
      dv_d[5]   = dv4_m;
      rd_d[5]   = rd_q[4];
      data_d[5] = data4_m;

      v_d[6]    = v_q[5];
      ld_d[6]   = ld_q[5];
      dv_d[6]   = dv_q[5];
      rd_d[6]   = rd_q[5];
      data_d[6] = data_q[5];
    end else begin
      dv_d[4]   = dv4_m;
      data_d[4] = data4_m;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v_q    <= '0;
      ld_q   <= '0;
      dv_q   <= '0;
      rd_q   <= '0;
      data_q <= '0;
      err_ld <= 1'b0;
    end else begin
      v_q    <= v_d;
      ld_q   <= ld_d;
      dv_q   <= dv_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      err_ld <= err_ld_d;
    end
  end

  // Returns {ok, data}.
  // An invalid slot falls back to the register file with ok low.
  function automatic logic [DATA_WIDTH:0] pick(input logic [2:0]            sel,
                                               input logic [DATA_WIDTH-1:0] rf);
    if (sel == 3'd0 || sel == 3'd7) begin
      return {1'b1, rf};
    end else if (v_q[sel]) begin
      return {dv_q[sel], data_q[sel]};
    end else begin
      return {1'b0, rf};
    end
  endfunction

  assign {RS1_DATA_OK, RS1_DATA} = pick(MUX1_SELECT, RS1_REGFILE);
  assign {RS2_DATA_OK, RS2_DATA} = pick(MUX2_SELECT, RS2_REGFILE);

  // One write per S5 entry: S5 only changes when adv is high.
  assign WB_EN   = v_q[5] & adv & (rd_q[5] != '0);
  assign WB_RD   = rd_q[5];
  assign WB_DATA = data_q[5];

endmodule

// File: tb/tb_fwd_data_pipe.sv
// Directed bench for fwd_data_pipe.
// Each issued result that must write back pushes {rd, data, cycle} into a queue.
// A negedge monitor pops the queue and compares whenever WB_EN is high.
module tb_fwd_data_pipe;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EX_VALID;
  logic [4:0]  EX_RD;
  logic [1:0]  EX_TYPE;
  logic [31:0] EX_RESULT;
  logic [31:0] LOAD_DATA;
  logic        LOAD_DATA_VALID;
  logic        DATA_CACHE_READY;
  logic        INS_CACHE_READY;
  logic        STALL_ENABLE_FB;
  logic        FLUSH;
  logic [2:0]  MUX1_SELECT;
  logic [2:0]  MUX2_SELECT;
  logic [31:0] RS1_REGFILE;
  logic [31:0] RS2_REGFILE;
  logic [31:0] RS1_DATA;
  logic [31:0] RS2_DATA;
  logic        RS1_DATA_OK;
  logic        RS2_DATA_OK;
  logic        WB_EN;
  logic [4:0]  WB_RD;
  logic [31:0] WB_DATA;

  localparam logic [31:0] Rf1 = 32'h1111_1111;
  localparam logic [31:0] Rf2 = 32'h2222_2222;

  fwd_data_pipe dut (
    .CLK              (CLK),
    .RST              (RST),
    .EX_VALID         (EX_VALID),
    .EX_RD            (EX_RD),
    .EX_TYPE          (EX_TYPE),
    .EX_RESULT        (EX_RESULT),
    .LOAD_DATA        (LOAD_DATA),
    .LOAD_DATA_VALID  (LOAD_DATA_VALID),
    .DATA_CACHE_READY (DATA_CACHE_READY),
    .INS_CACHE_READY  (INS_CACHE_READY),
    .STALL_ENABLE_FB  (STALL_ENABLE_FB),
    .FLUSH            (FLUSH),
    .MUX1_SELECT      (MUX1_SELECT),
    .MUX2_SELECT      (MUX2_SELECT),
    .RS1_REGFILE      (RS1_REGFILE),
    .RS2_REGFILE      (RS2_REGFILE),
    .RS1_DATA         (RS1_DATA),
    .RS2_DATA         (RS2_DATA),
    .RS1_DATA_OK      (RS1_DATA_OK),
    .RS2_DATA_OK      (RS2_DATA_OK),
    .WB_EN            (WB_EN),
    .WB_RD            (WB_RD),
    .WB_DATA          (WB_DATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } wb_t;

  wb_t exp_q[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Writeback monitor.
  always @(negedge CLK) begin
    if (!RST && WB_EN) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h cyc=%0d, want no write",
                 WB_RD, WB_DATA, cyc);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        if (WB_RD !== e.rd || WB_DATA !== e.data || cyc != e.cyc) begin
          bad++;
          $display("FAIL wb: got rd=%0d data=%h cyc=%0d, want rd=%0d data=%h cyc=%0d",
                   WB_RD, WB_DATA, cyc, e.rd, e.data, e.cyc);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Checks one operand port (1 or 2) for a select code.
  task automatic chk_sel(input int port, input logic [2:0] s, input logic [31:0] exp_d,
                         input logic exp_ok, input string nm);
    if (port == 1) begin
      MUX1_SELECT = s;
      #1;
      check({nm, "_data"}, RS1_DATA, exp_d);
      check({nm, "_ok"}, {31'd0, RS1_DATA_OK}, {31'd0, exp_ok});
    end else begin
      MUX2_SELECT = s;
      #1;
      check({nm, "_data"}, RS2_DATA, exp_d);
      check({nm, "_ok"}, {31'd0, RS2_DATA_OK}, {31'd0, exp_ok});
    end
  endtask

  // Issues one EX result; dly < 0 means no writeback is expected.
  // Otherwise the write is due dly cycles after the entry lands in S1.
  task automatic issue(input logic [1:0] ty, input logic [4:0] rd, input logic [31:0] res,
                       input int dly, input logic [31:0] wbd);
    wb_t e;
    EX_VALID  = 1'b1;
    EX_TYPE   = ty;
    EX_RD     = rd;
    EX_RESULT = res;
    tick();
    EX_VALID  = 1'b0;
    EX_TYPE   = 2'd0;
    if (dly >= 0) begin
      e.rd   = rd;
      e.data = wbd;
      e.cyc  = cyc + dly;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    RST = 1'b1;
    EX_VALID = 1'b0;
    EX_RD = '0;
    EX_TYPE = '0;
    EX_RESULT = '0;
    LOAD_DATA = '0;
    LOAD_DATA_VALID = 1'b0;
    DATA_CACHE_READY = 1'b1;
    INS_CACHE_READY = 1'b1;
    STALL_ENABLE_FB = 1'b1;
    FLUSH = 1'b0;
    MUX1_SELECT = '0;
    MUX2_SELECT = '0;
    RS1_REGFILE = Rf1;
    RS2_REGFILE = Rf2;

    // Reset state.
    #12;
    check("rst_wb_en", {31'd0, WB_EN}, 32'd0);
    check("rst_wb_rd", {27'd0, WB_RD}, 32'd0);
    check("rst_wb_data", WB_DATA, 32'd0);
    chk_sel(1, 3'd3, Rf1, 1'b0, "rst_sel3");
    chk_sel(1, 3'd0, Rf1, 1'b1, "rst_sel0");
    chk_sel(2, 3'd7, Rf2, 1'b1, "rst_sel7");
    check("rst_err_ld", {31'd0, dut.err_ld}, 32'd0);
    RST = 1'b0;
    tick();

    // ALU forward through all slots.
    issue(2'd1, 5'd5, 32'hA5A5_0001, 4, 32'hA5A5_0001);
    chk_sel(1, 3'd1, 32'hA5A5_0001, 1'b1, "alu_s1");
    chk_sel(2, 3'd2, Rf2, 1'b0, "empty_s2");
    repeat (4) tick();
    chk_sel(2, 3'd5, 32'hA5A5_0001, 1'b1, "alu_s5");
    tick();
    chk_sel(1, 3'd6, 32'hA5A5_0001, 1'b1, "alu_s6");
    tick();
    chk_sel(1, 3'd6, Rf1, 1'b0, "s6_gone");

    // Load merged while S4 holds under a data-cache stall.
    issue(2'd2, 5'd7, 32'hDEAD_BEEF, 5, 32'h1234_5678);
    chk_sel(1, 3'd1, 32'd0, 1'b0, "ld_s1");
    tick();
    chk_sel(1, 3'd2, 32'd0, 1'b0, "ld_s2");
    tick();
    chk_sel(1, 3'd3, 32'd0, 1'b0, "ld_s3");
    tick();
    DATA_CACHE_READY = 1'b0;
    LOAD_DATA = 32'h1234_5678;
    LOAD_DATA_VALID = 1'b1;
    chk_sel(1, 3'd4, 32'd0, 1'b0, "ld_s4_pre");
    tick();
    LOAD_DATA_VALID = 1'b0;
    LOAD_DATA = 32'hFFFF_FFFF;
    chk_sel(1, 3'd4, 32'h1234_5678, 1'b1, "ld_s4_merged");
    DATA_CACHE_READY = 1'b1;
    tick();
    chk_sel(2, 3'd5, 32'h1234_5678, 1'b1, "ld_s5");

    // Load merged in the same cycle S4 shifts into S5.
    issue(2'd2, 5'd8, 32'd0, 4, 32'hCAFE_F00D);
    repeat (3) tick();
    LOAD_DATA = 32'hCAFE_F00D;
    LOAD_DATA_VALID = 1'b1;
    tick();
    LOAD_DATA_VALID = 1'b0;
    chk_sel(1, 3'd5, 32'hCAFE_F00D, 1'b1, "ld_shift_s5");
    repeat (2) tick();

    // Cache stall: rd10 sits in S5, rd9 in S3.
    issue(2'd1, 5'd10, 32'h0000_010A, 7, 32'h0000_010A);
    tick();
    issue(2'd1, 5'd9, 32'h0000_0909, 7, 32'h0000_0909);
    tick();
    tick();
    DATA_CACHE_READY = 1'b0;
    #1;
    check("stall_no_wb", {31'd0, WB_EN}, 32'd0);
    repeat (3) tick();
    chk_sel(1, 3'd3, 32'h0000_0909, 1'b1, "stall_s3");
    chk_sel(2, 3'd5, 32'h0000_010A, 1'b1, "stall_s5");
    DATA_CACHE_READY = 1'b1;
    repeat (4) tick();

    // Flush kills S1/S2 and beats a same-cycle EX result; S3 survives.
    issue(2'd1, 5'd11, 32'h0000_0B0B, 4, 32'h0000_0B0B);
    issue(2'd1, 5'd12, 32'h0000_0C0C, -1, 32'd0);
    issue(2'd1, 5'd13, 32'h0000_0D0D, -1, 32'd0);
    FLUSH = 1'b1;
    EX_VALID = 1'b1;
    EX_TYPE = 2'd1;
    EX_RD = 5'd14;
    EX_RESULT = 32'h0000_0E0E;
    tick();
    FLUSH = 1'b0;
    EX_VALID = 1'b0;
    EX_TYPE = 2'd0;
    chk_sel(1, 3'd1, Rf1, 1'b0, "flush_s1");
    chk_sel(2, 3'd2, Rf2, 1'b0, "flush_s2");
    chk_sel(1, 3'd3, Rf1, 1'b0, "flush_s3");
    chk_sel(2, 3'd4, 32'h0000_0B0B, 1'b1, "flush_s4");
    repeat (6) tick();

    // STALL_ENABLE_FB low: S1 holds, bubble into S2, writeback one cycle late.
    issue(2'd1, 5'd3, 32'h0000_3333, 5, 32'h0000_3333);
    STALL_ENABLE_FB = 1'b0;
    tick();
    STALL_ENABLE_FB = 1'b1;
    chk_sel(1, 3'd1, 32'h0000_3333, 1'b1, "hold_s1");
    chk_sel(2, 3'd2, Rf2, 1'b0, "bubble_s2");
    tick();
    chk_sel(1, 3'd1, Rf1, 1'b0, "hold_s1_left");
    chk_sel(2, 3'd2, 32'h0000_3333, 1'b1, "hold_s2");
    repeat (5) tick();

    // rd=0 forwards but never writes; type 3 is idle.
    issue(2'd1, 5'd0, 32'h0000_0077, -1, 32'd0);
    chk_sel(1, 3'd1, 32'h0000_0077, 1'b1, "rd0_fwd");
    issue(2'd3, 5'd20, 32'h0000_0055, -1, 32'd0);
    chk_sel(1, 3'd1, Rf1, 1'b0, "type3_idle");
    repeat (6) tick();

    // Load reaching WB without data: writes zero and sets the sticky error.
    check("err_ld_clear", {31'd0, dut.err_ld}, 32'd0);
    issue(2'd2, 5'd19, 32'd0, 4, 32'd0);
    repeat (5) tick();
    check("err_ld_set", {31'd0, dut.err_ld}, 32'd1);
    repeat (2) tick();

    // Reset mid-flight with S1..S5 valid.
    for (int i = 0; i < 5; i++) begin
      issue(2'd1, 5'(21 + i), 32'h0000_5000 + 32'(i), -1, 32'd0);
    end
    check("pre_rst_wb_en", {31'd0, WB_EN}, 32'd1);
    #1;
    RST = 1'b1;
    #1;
    check("rst_mid_wb_en", {31'd0, WB_EN}, 32'd0);
    for (int s = 1; s <= 6; s++) begin
      chk_sel(1, 3'(s), Rf1, 1'b0, "rst_mid_sel");
    end
    check("rst_mid_wb_rd", {27'd0, WB_RD}, 32'd0);
    check("rst_mid_wb_data", WB_DATA, 32'd0);
    check("rst_mid_err_ld", {31'd0, dut.err_ld}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (8) tick();

    check("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
